// File: rtl/fan_pkg.sv
// Shared sizing and FSM state for the FAN reorder round scheduler.
package fan_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int NUM_PES     = 32;
  localparam int LOG2_PES    = 5;
  localparam int LOG2_HEIGHT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;
endpackage

// File: rtl/fan_winner_select.sv
// Per-slot winner pick: the highest-numbered pending PE targeting a slot is served.
// Combinational; the same priority as the reorder datapath's selection.
module fan_winner_select #(
  parameter int NUM_PES     = fan_pkg::NUM_PES,
  parameter int LOG2_HEIGHT = fan_pkg::LOG2_HEIGHT
) (
  input  logic [NUM_PES-1:0]             pending,
  input  logic [NUM_PES*LOG2_HEIGHT-1:0] index,
  output logic [NUM_PES-1:0]             served,
  output logic [NUM_PES-1:0]             slot_hit
);
  localparam int NUM_SLOTS = 1 << LOG2_HEIGHT;

  logic [NUM_SLOTS-1:0] taken;

  // Scanning from the top PE down, the first claimant of a slot wins it.
  always_comb begin
    served   = '0;
    taken    = '0;
    slot_hit = '0;
    for (int j = NUM_PES - 1; j >= 0; j--) begin
      if (pending[j] && !taken[index[j*LOG2_HEIGHT +: LOG2_HEIGHT]]) begin
        served[j] = 1'b1;
        taken[index[j*LOG2_HEIGHT +: LOG2_HEIGHT]] = 1'b1;
      end
    end
    slot_hit[NUM_SLOTS-1:0] = taken;
  end
endmodule

// File: rtl/fan_reorder_sched.sv
// Round scheduler: latches a batch, issues it to the reorder datapath one collision-free
// round per cycle, and emits slot-valid/round/last aligned with the reorder output register.
module fan_reorder_sched #(
  parameter int DATA_WIDTH  = fan_pkg::DATA_WIDTH,
  parameter int NUM_PES     = fan_pkg::NUM_PES,
  parameter int LOG2_PES    = fan_pkg::LOG2_PES,
  parameter int LOG2_HEIGHT = fan_pkg::LOG2_HEIGHT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_PES*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_PES-1:0]              s_pe_valid,
  input  logic [NUM_PES*LOG2_HEIGHT-1:0]  s_index,
  output logic [NUM_PES*DATA_WIDTH-1:0]   o_fr_data,
  output logic [NUM_PES-1:0]              o_fr_valid,
  output logic [NUM_PES*LOG2_HEIGHT-1:0]  o_fr_index,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_PES-1:0]              m_slot_valid,
  output logic [LOG2_PES-1:0]             m_round,
  output logic                            m_last,
  output logic                            o_busy
);
  import fan_pkg::*;

  state_t                           state;
  logic [NUM_PES-1:0]               pending;
  logic [NUM_PES-1:0]               served;
  logic [NUM_PES-1:0]               slot_hit;
  logic [NUM_PES-1:0]               remain;
  logic [LOG2_PES-1:0]              round_cnt;
  logic [NUM_PES*DATA_WIDTH-1:0]    data_q;
  logic [NUM_PES*LOG2_HEIGHT-1:0]   index_q;
  logic                             issuing;
  logic                             advance;
  logic                             last;
  logic                             accept;

  fan_winner_select #(
    .NUM_PES     (NUM_PES),
    .LOG2_HEIGHT (LOG2_HEIGHT)
  ) u_winner (
    .pending  (pending),
    .index    (index_q),
    .served   (served),
    .slot_hit (slot_hit)
  );

  assign issuing    = (state == ISSUE);
  assign advance    = !m_valid || m_ready;
  assign remain     = pending & ~served;
  assign last       = (remain == '0);
  // Ready again on the final round so the next batch follows without a bubble.
  assign s_ready    = !issuing || (advance && last);
  assign accept     = s_valid && s_ready;
  assign o_busy     = issuing;
  assign o_fr_valid = issuing ? pending : '0;
  assign o_fr_data  = data_q;
  assign o_fr_index = index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      round_cnt <= '0;
      data_q    <= '0;
      index_q   <= '0;
    end else begin
      if (issuing && advance) begin
        pending   <= remain;
        round_cnt <= round_cnt + LOG2_PES'(1);
        if (last) state <= IDLE;
      end
      // An empty batch is latched but never enters ISSUE.
      if (accept) begin
        data_q    <= s_data;
        index_q   <= s_index;
        pending   <= s_pe_valid;
        round_cnt <= '0;
        state     <= (s_pe_valid != '0) ? ISSUE : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid      <= 1'b0;
      m_slot_valid <= '0;
      m_round      <= '0;
      m_last       <= 1'b0;
    end else if (issuing && advance) begin
      m_valid      <= 1'b1;
      m_slot_valid <= slot_hit;
      m_round      <= round_cnt;
      m_last       <= last;
    end else if (m_ready) begin
      m_valid      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fan_reorder_sched.sv
// Bench for fan_reorder_sched: directed scenarios plus random batches against a round-list model.
module tb_fan_reorder_sched;
  localparam int NP = 32;
  localparam int DW = 32;
  localparam int LH = 4;
  localparam int LP = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [NP*DW-1:0]     s_data;
  logic [NP-1:0]        s_pe_valid;
  logic [NP*LH-1:0]     s_index;
  logic [NP*DW-1:0]     o_fr_data;
  logic [NP-1:0]        o_fr_valid;
  logic [NP*LH-1:0]     o_fr_index;
  logic                 m_valid;
  logic                 m_ready;
  logic [NP-1:0]        m_slot_valid;
  logic [LP-1:0]        m_round;
  logic                 m_last;
  logic                 o_busy;

  always #5 clk = ~clk;

  fan_reorder_sched #(
    .DATA_WIDTH (DW), .NUM_PES (NP), .LOG2_PES (LP), .LOG2_HEIGHT (LH)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .s_pe_valid (s_pe_valid), .s_index (s_index),
    .o_fr_data (o_fr_data), .o_fr_valid (o_fr_valid), .o_fr_index (o_fr_index),
    .m_valid (m_valid), .m_ready (m_ready), .m_slot_valid (m_slot_valid),
    .m_round (m_round), .m_last (m_last), .o_busy (o_busy)
  );

  typedef struct packed {
    logic [NP-1:0] pend;
    logic [NP-1:0] sv;
    logic [LP-1:0] rnd;
    logic          last;
  } rnd_t;

  rnd_t             rq[$];
  rnd_t             mreg;
  bit               mv;
  logic [NP*DW-1:0] cur_data;
  logic [NP*LH-1:0] cur_idx;
  int               n_cmp = 0;
  int               n_fail = 0;
  bit               rand_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
    bit shown;
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      shown = 0;
      for (int w = 0; w < NP; w++)
        if (!shown && act[w*DW +: DW] !== exp[w*DW +: DW]) begin
          shown = 1;
          $display("FAIL %s: word %0d got %h expected %h at %0t", name, w,
                   act[w*DW +: DW], exp[w*DW +: DW], $time);
        end
    end
  endtask

  // Expand a batch into its round list: each slot goes to its highest pending PE.
  task automatic model_batch(input logic [NP-1:0] pv, input logic [NP*LH-1:0] idx);
    logic [NP-1:0] pend, served, sv;
    bit            found;
    int            r;
    rnd_t          e;
    pend = pv;
    r = 0;
    while (pend != '0) begin
      served = '0;
      sv = '0;
      for (int k = 0; k < (1 << LH); k++) begin
        found = 0;
        for (int j = NP - 1; j >= 0; j--)
          if (!found && pend[j] && int'(idx[j*LH +: LH]) == k) begin
            found = 1;
            served[j] = 1'b1;
            sv[k] = 1'b1;
          end
      end
      e.pend = pend;
      e.sv   = sv;
      e.rnd  = LP'(r);
      e.last = ((pend & ~served) == '0);
      rq.push_back(e);
      pend = pend & ~served;
      r++;
    end
  endtask

  always @(negedge clk) begin : compare
    bit busy, adv, exp_rdy;
    if (!rst_n) begin
      rq.delete();
      mv = 0;
    end else begin
      busy    = (rq.size() != 0);
      adv     = !mv || m_ready;
      exp_rdy = !busy;
      if (busy && adv && rq[0].last) exp_rdy = 1;
      chk("o_busy", o_busy, busy);
      chk("s_ready", s_ready, exp_rdy);
      chk("m_valid", m_valid, mv);
      if (busy) begin
        chk("o_fr_valid", o_fr_valid, rq[0].pend);
        chk_data("o_fr_data", o_fr_data, cur_data);
        chk("o_fr_index", o_fr_index, cur_idx);
      end else begin
        chk("o_fr_valid_idle", o_fr_valid, 0);
      end
      if (mv) begin
        chk("m_slot_valid", m_slot_valid, mreg.sv);
        chk("m_round", m_round, mreg.rnd);
        chk("m_last", m_last, mreg.last);
      end
      if (busy && adv) begin
        mreg = rq.pop_front();
        mv = 1;
      end else if (m_ready) begin
        mv = 0;
      end
      if (s_valid && exp_rdy) begin
        cur_data = s_data;
        cur_idx  = s_index;
        model_batch(s_pe_valid, s_index);
      end
    end
  end

  function automatic logic [NP*LH-1:0] idx_all(input int v);
    logic [NP*LH-1:0] r;
    for (int j = 0; j < NP; j++) r[j*LH +: LH] = LH'(v);
    return r;
  endfunction

  task automatic rand_data();
    for (int w = 0; w < NP; w++) s_data[w*DW +: DW] = $urandom;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [NP-1:0] pv, input logic [NP*LH-1:0] idx, input bit hold);
    s_valid = 1'b1;
    s_pe_valid = pv;
    s_index = idx;
    rand_data();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_valid) return;
    end
    chk("m_valid_timeout", 0, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_o_fr_valid"}, o_fr_valid, 0);
    chk_data({tag, "_o_fr_data"}, o_fr_data, '0);
    chk({tag, "_o_fr_index"}, o_fr_index, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_slot_valid"}, m_slot_valid, 0);
    chk({tag, "_m_round"}, m_round, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_o_busy"}, o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0]    pv;
    logic [NP*LH-1:0] idx;
    int               n, run, rng;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_pe_valid = '0; s_index = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // PE j -> slot j for j < 16: a single full round.
    pv = 32'h0000_FFFF;
    idx = '0;
    for (int j = 0; j < 16; j++) idx[j*LH +: LH] = LH'(j);
    send(pv, idx, 0);
    @(negedge clk);
    chk("t1_m_valid_T1", m_valid, 0);
    chk("t1_fr_valid_T1", o_fr_valid, 32'h0000_FFFF);
    @(negedge clk);
    chk("t1_m_valid_T2", m_valid, 1);
    chk("t1_slot_valid", m_slot_valid, 32'h0000_FFFF);
    chk("t1_round", m_round, 0);
    chk("t1_last", m_last, 1);
    repeat (2) @(posedge clk); #1;

    // All PEs to slot 3: 32 rounds, PE31 first.
    send('1, idx_all(3), 0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) chk("t2_fr_valid_r0", o_fr_valid, 32'hFFFF_FFFF);
      if (c == 1) chk("t2_fr_valid_r1", o_fr_valid, 32'h7FFF_FFFF);
      if (m_valid && m_ready) begin
        if (n == 0) chk("t2_slot_valid", m_slot_valid, 32'h8);
        n++;
        if (m_last) break;
      end
    end
    chk("t2_rounds", n, 32);
    @(posedge clk); #1;

    // Empty batch is accepted and dropped.
    send('0, idx_all(1), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_m_valid", m_valid, 0);
      chk("t3_s_ready", s_ready, 1);
      chk("t3_o_busy", o_busy, 0);
    end
    @(posedge clk); #1;

    // PE5 and PE9 collide on slot 2, with the consumer stalled on round 0.
    m_ready = 1'b0;
    idx = '0;
    idx[5*LH +: LH] = 4'd2;
    idx[9*LH +: LH] = 4'd2;
    send((32'h1 << 5) | (32'h1 << 9), idx, 0);
    wait_mvalid();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_round", m_round, 0);
      chk("t4_hold_fr_valid", o_fr_valid, 32'h20);
      chk("t4_hold_slot", m_slot_valid, 32'h4);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("t4_round0_again", m_round, 0);
    @(negedge clk);
    chk("t4_round1", m_round, 1);
    chk("t4_round1_last", m_last, 1);
    chk("t4_round1_slot", m_slot_valid, 32'h4);
    @(posedge clk); #1;

    // Back-to-back batches (2 + 3 rounds) with s_valid held high.
    run = 0;
    fork
      begin
        send(32'h3, idx_all(0), 1);
        send(32'h1C, idx_all(1), 0);
      end
      begin
        wait_mvalid();
        for (int c = 0; c < 20 && m_valid; c++) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("t5_gapless_run", run, 5);
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a 10-round batch.
    send(32'h3FF, idx_all(7), 0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_valid && m_round == 4) break;
    end
    chk("t6_reached_round4", m_round, 4);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    idx = '0;
    idx[3*LH +: LH] = 4'd5;
    send(32'hF, idx, 0);
    wait_mvalid();
    chk("t6_next_round0", m_round, 0);
    repeat (4) @(posedge clk); #1;

    // Random batches with random backpressure.
    rand_done = 0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          case ($urandom_range(0, 3))
            0: rng = 0;
            1: rng = 1;
            2: rng = 3;
            default: rng = 15;
          endcase
          pv = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
          for (int j = 0; j < NP; j++) idx[j*LH +: LH] = LH'($urandom_range(0, rng));
          send(pv, idx, 0);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int c = 0; c < 200 && (o_busy || m_valid); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_idle", {o_busy, m_valid}, 0);
    chk("model_queue_empty", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
